// File: rtl/i2s_rx_stream.sv
`timescale 1ns/1ps
// i2s_rx_stream
//   Captures I2S record audio from a codec running on its own bit clock and
//   presents each left/right pair as one 64-bit AXI-Stream beat, grouped into
//   packets of PACKET_LEN frames.
// Ports:
//   m_axis_aclk / m_axis_aresetn : sole clock, async active-low reset
//   ac_bclk / ac_reclrc / ac_recdat : codec bit clock, LR clock (low = left), data
//   rx_enable      : capture enable (FIFO keeps draining when low)
//   overflow_clear : single-cycle pulse clearing the sticky overflow flag
//   m_axis_*       : stream master, tdata = {right[31:0], left[31:0]}
//   overflow       : sticky flag, a frame was dropped on a full buffer
module i2s_rx_stream #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int PACKET_LEN = 256
) (
  input  logic        m_axis_aclk,
  input  logic        m_axis_aresetn,
  input  logic        ac_bclk,
  input  logic        ac_reclrc,
  input  logic        ac_recdat,
  input  logic        rx_enable,
  input  logic        overflow_clear,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        overflow
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int FCW = $clog2(PACKET_LEN + 1);
  localparam int BCW = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0]  DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [PW-1:0]  PTR_ONE   = PW'(1);
  localparam logic [FCW-1:0] LAST_CNT  = FCW'(PACKET_LEN - 1);
  localparam logic [FCW-1:0] FC_ONE    = FCW'(1);
  localparam logic [BCW-1:0] DW_CNT    = BCW'(DATA_WIDTH);
  localparam logic [BCW-1:0] BC_ONE    = BCW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  function automatic logic [31:0] sext32(input logic [DATA_WIDTH-1:0] w);
    return 32'($signed(w));
  endfunction

  logic [2:0]            sync1_q, sync1_d, sync2_q, sync2_d;
  logic                  bclk_prev_q, bclk_prev_d, lr_prev_q, lr_prev_d;
  logic                  bit_stb_s, lr_s, dat_s, lr_chg_s;
  logic [1:0]            state_q, state_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d, left_q, left_d, aligned_s;
  logic                  push_req_s;
  logic [64:0]           mem_q [FIFO_DEPTH];
  logic [64:0]           mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FCW-1:0]        fcnt_q, fcnt_d;
  logic                  overflow_q, overflow_d;
  logic                  pop_s, full_s, push_ok_s, drop_s, last_s;

  // Synchronizer chain, bit strobe and LR-change detection
  always_comb begin
    sync1_d     = {ac_bclk, ac_reclrc, ac_recdat};
    sync2_d     = sync1_q;
    bclk_prev_d = sync2_q[2];
    bit_stb_s   = sync2_q[2] & ~bclk_prev_q;
    lr_s        = sync2_q[1];
    dat_s       = sync2_q[0];
    lr_chg_s    = bit_stb_s & (lr_s != lr_prev_q);
    if (bit_stb_s) begin
      lr_prev_d = lr_s;
    end else begin
      lr_prev_d = lr_prev_q;
    end
    // Left-align a short half-frame; missing LSBs become zero
    aligned_s = sh_q << (DW_CNT - bit_cnt_q);
  end

  // Capture FSM: delay-slot discard, MSB-first shifting, frame push request
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    left_d     = left_q;
    push_req_s = 1'b0;
    if (!rx_enable) begin
      state_d   = ST_IDLE;
      bit_cnt_d = {BCW{1'b0}};
      sh_d      = {DATA_WIDTH{1'b0}};
    end else if (bit_stb_s) begin
      case (state_q)
        ST_IDLE: begin
          // Only a high->low LR change marks the start of a complete frame
          if (lr_chg_s && !lr_s) begin
            state_d   = ST_LEFT;
            bit_cnt_d = {BCW{1'b0}};
            sh_d      = {DATA_WIDTH{1'b0}};
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LEFT, ST_RIGHT: begin
          if (lr_chg_s) begin
            // This strobe is the delay slot of the next half-frame
            bit_cnt_d = {BCW{1'b0}};
            sh_d      = {DATA_WIDTH{1'b0}};
            if (state_q == ST_LEFT) begin
              left_d  = aligned_s;
              state_d = ST_RIGHT;
            end else begin
              push_req_s = 1'b1;
              state_d    = ST_LEFT;
            end
          end else if (bit_cnt_q < DW_CNT) begin
            sh_d      = {sh_q[DATA_WIDTH-2:0], dat_s};
            bit_cnt_d = bit_cnt_q + BC_ONE;
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          bit_cnt_d = {BCW{1'b0}};
          sh_d      = {DATA_WIDTH{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Frame buffer, packet counter and overflow flag
  always_comb begin
    pop_s     = (count_q != {CW{1'b0}}) && m_axis_tready;
    full_s    = (count_q == DEPTH_CNT);
    // A pop in the same cycle frees the slot, so a full buffer still accepts
    push_ok_s = push_req_s && (!full_s || pop_s);
    drop_s    = push_req_s && full_s && !pop_s;
    last_s    = (fcnt_q == LAST_CNT);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    fcnt_d    = fcnt_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = {last_s, sext32(aligned_s), sext32(left_q)};
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
      if (last_s) begin
        fcnt_d = {FCW{1'b0}};
      end else begin
        fcnt_d = fcnt_q + FC_ONE;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // Set wins over a coincident clear
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (overflow_clear) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      sync1_q     <= 3'b000;
      sync2_q     <= 3'b000;
      bclk_prev_q <= 1'b0;
      lr_prev_q   <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= {BCW{1'b0}};
      sh_q        <= {DATA_WIDTH{1'b0}};
      left_q      <= {DATA_WIDTH{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 65'd0;
      end
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      fcnt_q      <= {FCW{1'b0}};
      overflow_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      bclk_prev_q <= bclk_prev_d;
      lr_prev_q   <= lr_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      left_q      <= left_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fcnt_q      <= fcnt_d;
      overflow_q  <= overflow_d;
    end
  end

  assign m_axis_tvalid = (count_q != {CW{1'b0}});
  assign m_axis_tdata  = mem_q[rd_ptr_q][63:0];
  assign m_axis_tlast  = mem_q[rd_ptr_q][64];
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_i2s_rx_stream.sv
`timescale 1ns/1ps
// Bench for i2s_rx_stream: an I2S transmitter model drives the codec pins,
// expected beats are queued per frame and a monitor checks every handshake.
module tb_i2s_rx_stream;

  logic        clk, rst_n, bclk, lr, dat, rx_en, ov_clr, tvalid, tready, tlast, ovf;
  logic [63:0] tdata;

  int          total = 0;
  int          bad = 0;
  int          acc_cnt = 0;
  logic [64:0] exp_q[$];
  bit          rand_rdy = 1'b0;
  logic        prev_lsb = 1'b0;
  logic        stall_q = 1'b0;
  logic [64:0] held = 65'd0;

  i2s_rx_stream #(.DATA_WIDTH(24), .FIFO_DEPTH(4), .PACKET_LEN(4)) dut (
    .m_axis_aclk(clk), .m_axis_aresetn(rst_n),
    .ac_bclk(bclk), .ac_reclrc(lr), .ac_recdat(dat),
    .rx_enable(rx_en), .overflow_clear(ov_clr),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tdata(tdata), .m_axis_tlast(tlast), .overflow(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900us;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  // Random backpressure, changed just after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) tready = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every handshake pops one expected beat; stalled beats must hold
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        total++;
        if (!(tvalid === 1'b1 && {tlast, tdata} === held)) begin
          bad++;
          $display("FAIL hold: got valid=%b %h want valid=1 %h", tvalid, {tlast, tdata}, held);
        end
      end
      if (tvalid && tready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat: got %h want no beat", {tlast, tdata});
        end else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          if ({tlast, tdata} !== e) begin
            bad++;
            $display("FAIL beat: got %h want %h", {tlast, tdata}, e);
          end
        end
      end
      stall_q = tvalid && !tready;
      held    = {tlast, tdata};
    end
  end

  // Reference: first min(n,24) received bits, left-aligned, sign-extended
  function automatic logic [31:0] model_word(input logic [31:0] bits, input int n);
    longint unsigned v;
    v = bits;
    if (n >= 24) v = (v >> (n - 24)) & 64'hFFFFFF;
    else         v = (v << (24 - n)) & 64'hFFFFFF;
    if (v >= 64'h800000) v = v | 64'hFFFF_FFFF_FF00_0000;
    return v[31:0];
  endfunction

  task automatic push_exp(input logic [63:0] d);
    exp_q.push_back({(acc_cnt % 4 == 3) ? 1'b1 : 1'b0, d});
    acc_cnt++;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bclk period; optionally open tready for exactly the cycle this
  // bit's rising edge reaches the capture logic (two sync flops + edge detect)
  task automatic send_bit(input logic l, input logic d, input bit pop);
    time t0;
    bclk = 1'b0; lr = l; dat = d;
    #40;
    bclk = 1'b1;
    t0 = $time;
    if (pop) begin
      repeat (2) @(posedge clk);
      #1 tready = 1'b1;
      @(posedge clk);
      #1 tready = 1'b0;
      #(t0 + 40 - $time);
    end else begin
      #40;
    end
  endtask

  task automatic send_half(input logic l, input logic [31:0] val, input int n, input int slot);
    logic b;
    send_bit(l, prev_lsb, 1'b0);
    for (int i = 0; i < slot; i++) begin
      b = (i < n) ? val[n-1-i] : 1'b0;
      send_bit(l, b, 1'b0);
      prev_lsb = b;
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n, input int slot);
    send_half(1'b0, l, n, slot);
    send_half(1'b1, r, n, slot);
  endtask

  task automatic rand_frame(input int n, input int slot, input bit accepted);
    logic [31:0] mask, l, r;
    mask = 32'((64'd1 << n) - 64'd1);
    l = $urandom & mask;
    r = $urandom & mask;
    send_frame(l, r, n, slot);
    if (accepted) push_exp({model_word(r, n), model_word(l, n)});
  endtask

  task automatic preamble();
    repeat (3) send_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic tail(input bit pop);
    send_bit(1'b0, prev_lsb, pop);
    repeat (2) send_bit(1'b0, 1'b0, 1'b0);
    wait_cycles(10);
  endtask

  task automatic restart();
    rx_en = 1'b0;
    wait_cycles(4);
    rx_en = 1'b1;
    wait_cycles(2);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    wait_cycles(3);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: got %0d beats pending want 0", name, exp_q.size());
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tvalid"}, {64'd0, tvalid}, 65'd0);
    chk({tag, "_tlast"}, {64'd0, tlast}, 65'd0);
    chk({tag, "_tdata"}, {1'b0, tdata}, 65'd0);
    chk({tag, "_ovf"}, {64'd0, ovf}, 65'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    acc_cnt = 0;
    #20;
    check_reset_vals("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; bclk = 1'b0; lr = 1'b0; dat = 1'b0;
    rx_en = 1'b1; ov_clr = 1'b0; tready = 1'b0;
    #2 rst_n = 1'b0;
    exp_q.delete();
    acc_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst_n = 1'b1;
    wait_cycles(4);

    // Basic 24-bit frame in 32-bit slots
    tready = 1'b1;
    preamble();
    send_frame(32'h00123456, 32'h00ABCDEF, 24, 32);
    push_exp(64'hFFABCDEF_00123456);
    tail(1'b0);
    wait_drain("basic_drain");
    restart();

    // Short half-frames of 16 bits
    preamble();
    send_frame(32'h0000FFFF, 32'h00000001, 16, 16);
    push_exp(64'h00000100_FFFFFF00);
    tail(1'b0);
    wait_drain("short_drain");
    restart();

    // Backpressure: fifth frame dropped, overflow sticky until cleared
    tready = 1'b0;
    preamble();
    for (int i = 0; i < 5; i++) rand_frame(24, 32, (i < 4));
    tail(1'b0);
    chk("ovf_set", {64'd0, ovf}, 65'd1);
    chk("full_valid", {64'd0, tvalid}, 65'd1);
    tready = 1'b1;
    wait_drain("ovf_drain");
    wait_cycles(20);
    chk("ovf_sticky", {64'd0, ovf}, 65'd1);
    ov_clr = 1'b1;
    wait_cycles(1);
    ov_clr = 1'b0;
    wait_cycles(1);
    chk("ovf_cleared", {64'd0, ovf}, 65'd0);
    restart();

    // Full buffer: push and pop in the same cycle
    tready = 1'b0;
    preamble();
    for (int i = 0; i < 5; i++) rand_frame(24, 32, 1'b1);
    tail(1'b1);
    chk("full_pushpop_ovf", {64'd0, ovf}, 65'd0);
    tready = 1'b1;
    wait_drain("full_drain");
    restart();

    // Packet boundary from a fresh counter, random lengths and backpressure
    do_reset();
    wait_cycles(4);
    rand_rdy = 1'b1;
    preamble();
    for (int i = 0; i < 9; i++) begin
      int n;
      n = $urandom_range(8, 28);
      rand_frame(n, n + $urandom_range(0, 4), 1'b1);
    end
    tail(1'b0);
    wait_drain("packet_drain");
    chk("packet_ovf", {64'd0, ovf}, 65'd0);
    restart();

    // rx_enable dropped mid-left: partial frame never appears
    preamble();
    rand_frame(24, 32, 1'b1);
    send_bit(1'b0, prev_lsb, 1'b0);
    repeat (10) send_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    rx_en = 1'b0;
    repeat (20) send_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    rx_en = 1'b1;
    send_half(1'b1, $urandom, 24, 32);
    rand_frame(24, 32, 1'b1);
    tail(1'b0);
    wait_drain("enable_drain");
    restart();

    // Reset pulsed mid-right: nothing partial survives
    preamble();
    rand_frame(24, 32, 1'b1);
    send_half(1'b0, $urandom, 24, 32);
    send_bit(1'b1, prev_lsb, 1'b0);
    repeat (10) send_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    do_reset();
    repeat (10) send_bit(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    rand_frame(24, 32, 1'b1);
    tail(1'b0);
    wait_drain("reset_drain");
    chk("final_ovf", {64'd0, ovf}, 65'd0);

    rand_rdy = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_rx_stream.md
I2S_RX_STREAM -- requirements
Module: i2s_rx_stream

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, 24, captured bits per channel.
- FIFO_DEPTH, 4, frame buffer entries (power of 2).
- PACKET_LEN, 256, frames per AXI-Stream packet.

REQ-002 The block SHALL use one clock; reset is asynchronous and active-low. Ports, one per line (name, direction, width, meaning):
- m_axis_aclk, in, 1, sole clock.
- m_axis_aresetn, in, 1, async active-low reset.
- ac_bclk, in, 1, codec bit clock, asynchronous.
- ac_reclrc, in, 1, codec record LR clock, asynchronous; low = left.
- ac_recdat, in, 1, codec record serial data, asynchronous.
- rx_enable, in, 1, capture enable.
- overflow_clear, in, 1, clears overflow (single-cycle pulse).
- m_axis_tvalid, out, 1, data valid.
- m_axis_tready, in, 1, downstream ready.
- m_axis_tdata, out, 64, {right[31:0], left[31:0]}.
- m_axis_tlast, out, 1, last frame of packet.
- overflow, out, 1, sticky frame-drop flag.

Function
REQ-003 ac_bclk, ac_reclrc and ac_recdat SHALL each pass through a 2-flop synchronizer; a bclk rising edge is detected from synchronized samples and produces a one-cycle "bit strobe".
REQ-004 ac_reclrc and ac_recdat SHALL be sampled only on the bit strobe.
REQ-005 LR change detect: on a bit strobe where sampled LR differs from the previous strobe's LR, that bit is the I2S delay slot; it is discarded and the bit counter resets to 0.
REQ-006 State machine SHALL have three states:
- IDLE: wait for the first LR high->low change, then go to LEFT.
- LEFT: on LR low->high change, go to RIGHT.
- RIGHT: on LR high->low change, push the frame and go to LEFT.
REQ-007 In LEFT/RIGHT, the first DATA_WIDTH strobes after the delay slot SHALL shift data in MSB first; further bits in that half-frame are ignored.
REQ-008 Short half-frame (fewer than DATA_WIDTH bits before the LR change): captured bits SHALL be left-aligned and the missing LSBs zero-filled.
REQ-009 Each channel word SHALL be sign-extended from DATA_WIDTH to 32 bits; left goes in tdata[31:0], right in tdata[63:32].
REQ-010 Push happens on the RIGHT->LEFT transition; that same strobe also starts the new left channel.
REQ-011 FIFO behaviour:
- FIFO_DEPTH entries, each 65 bits (tdata + tlast).
- A beat transfers when tvalid && tready.
- tvalid SHALL assert the cycle after a push into an empty FIFO.
- tdata/tlast SHALL be stable while tvalid && !tready.
REQ-012 Simultaneous push and pop on a full FIFO SHALL succeed with no drop.
REQ-013 Push into a full FIFO (no pop that cycle) SHALL drop the frame and set overflow.
REQ-014 overflow SHALL stay set until an overflow_clear pulse; if a set and a clear occur in the same cycle, set wins.
REQ-015 Frame counter:
- 0..PACKET_LEN-1, increments per accepted push (dropped frames not counted).
- tlast=1 on the frame pushed at count PACKET_LEN-1; counter then wraps to 0.
REQ-016 When rx_enable=0:
- FSM forced to IDLE; bit counter and shift register cleared; no pushes.
- FIFO continues to drain normally.
- Frame counter holds its value.
REQ-017 When rx_enable rises, capture SHALL resume from IDLE, so the first pushed frame is always a complete left/right pair.

Reset
REQ-018 While m_axis_aresetn=0, all of the following SHALL hold:
- m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, overflow=0.
- FIFO empty, FSM in IDLE, frame counter 0, synchronizers 0.
REQ-019 Reset asserted mid-frame or mid-transfer SHALL discard all partial and buffered data with no pending beat.
REQ-020 After reset release, no push SHALL occur before the first LR high->low change.

Verification
REQ-021 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Basic frame: bclk = clk/8, 32-bit slots, left=24'h123456, right=24'hABCDEF, tready=1 -> one beat, tdata=64'hFFABCDEF_00123456, tlast=0.
- Backpressure/overflow: tready=0, 5 frames -> 4 beats buffered, overflow=1, 5th frame absent. Then tready=1 -> 4 beats in order, overflow stays 1 until an overflow_clear pulse.
- Packet boundary: PACKET_LEN=4, 9 frames -> tlast on beats 4 and 8 only.
- Short half-frame: 16-bit slots, left bits 16'hFFFF, right bits 16'h0001 -> tdata=64'h00000100_FFFFFF00.
- Enable/reset mid-frame: rx_enable dropped mid-left, or m_axis_aresetn pulsed mid-right -> no partial frame emitted; the next beat is the first complete frame after the next LR high->low change.
- Full FIFO: simultaneous pop and push while full -> no overflow, beat order preserved.
